mul_share_arb: RTL and testbench

Round-robin arbiter and sequencer that shares one combinational unsigned multiplier among NUM_REQ requesters. Each requester presents an operand pair with a valid/ready handshake. The block grants one requester and drives the multiplier operands for one cycle. It then registers the product and returns it on a shared response channel tagged with the requester ID. It sits between requesting datapath units and a single multiplier instance external to this block.

---
 rtl/mul_share_arb.sv | 135 +++++++++++++
 tb/tb_mul_share_arb.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mul_share_arb.sv
// mul_share_arb: round-robin arbiter that shares one external combinational
// unsigned multiplier among NUM_REQ requesters, one transaction at a time.
// States: IDLE (arbitrate and accept), MUL (operands presented), RESP (hold the response).
// Optional build macro MUL_SHARE_ARB_STATS_EN adds a saturating ops_done counter.
module mul_share_arb #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 2,
  parameter int ID_W    = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [WIDTH-1:0]         mul_a,
  output logic [WIDTH-1:0]         mul_b,
  input  logic [2*WIDTH-1:0]       mul_product,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [2*WIDTH-1:0]       rsp_product
`ifdef MUL_SHARE_ARB_STATS_EN
  ,
  output logic [15:0]              ops_done
`endif
);

  typedef enum logic [1:0] {IDLE, MUL, RESP} state_t;

  state_t               state_q, state_d;
  logic [ID_W-1:0]      last_grant_q, last_grant_d;
  logic [ID_W-1:0]      rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0]     op_a_q, op_a_d;
  logic [WIDTH-1:0]     op_b_q, op_b_d;
  logic [2*WIDTH-1:0]   rsp_product_q, rsp_product_d;

  logic                 found;
  logic [ID_W-1:0]      winner;
  logic [WIDTH-1:0]     win_a, win_b;
  int unsigned          idx;

  // Round-robin search starting one past the last grant, wrapping modulo NUM_REQ
  always_comb begin
    found  = 1'b0;
    winner = '0;
    win_a  = '0;
    win_b  = '0;
    idx    = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = (32'(last_grant_q) + k) % NUM_REQ;
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        winner = ID_W'(idx);
        win_a  = req_a[idx*WIDTH +: WIDTH];
        win_b  = req_b[idx*WIDTH +: WIDTH];
      end
    end
  end

  // Next-state and handshake logic
  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    rsp_id_d      = rsp_id_q;
    op_a_d        = op_a_q;
    op_b_d        = op_b_q;
    rsp_product_d = rsp_product_q;
    req_ready     = '0;
    case (state_q)
      IDLE: begin
        if (found) begin
          req_ready    = NUM_REQ'(1) << winner;
          op_a_d       = win_a;
          op_b_d       = win_b;
          rsp_id_d     = winner;
          last_grant_d = winner;
          state_d      = MUL;
        end
      end
      MUL: begin
        rsp_product_d = mul_product;
        state_d       = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      last_grant_q  <= ID_W'(NUM_REQ - 1);
      rsp_id_q      <= '0;
      op_a_q        <= '0;
      op_b_q        <= '0;
      rsp_product_q <= '0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      rsp_id_q      <= rsp_id_d;
      op_a_q        <= op_a_d;
      op_b_q        <= op_b_d;
      rsp_product_q <= rsp_product_d;
    end
  end

  assign mul_a       = op_a_q;
  assign mul_b       = op_b_q;
  assign rsp_valid   = (state_q == RESP);
  assign rsp_id      = rsp_id_q;
  assign rsp_product = rsp_product_q;

`ifdef MUL_SHARE_ARB_STATS_EN
  logic [15:0] ops_done_q, ops_done_d;

  // Saturating count of completed response handshakes
  always_comb begin
    ops_done_d = ops_done_q;
    if (rsp_valid && rsp_ready && (ops_done_q != '1)) ops_done_d = ops_done_q + 16'd1;
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ops_done_q <= '0;
    else        ops_done_q <= ops_done_d;
  end

  assign ops_done = ops_done_q;
`endif

endmodule

// File: tb/tb_mul_share_arb.sv
// Directed testbench for mul_share_arb with a behavioural external multiplier.
module tb_mul_share_arb;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req_valid;
  logic [3:0] req_ready;
  logic [7:0] req_a, req_b;
  logic [1:0] mul_a, mul_b;
  logic [3:0] mul_product;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [1:0] rsp_id;
  logic [3:0] rsp_product;
`ifdef MUL_SHARE_ARB_STATS_EN
  logic [15:0] ops_done;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // Shared multiplier outside the arbiter
  assign mul_product = mul_a * mul_b;

  mul_share_arb #(.NUM_REQ(4), .WIDTH(2), .ID_W(2)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_a(req_a),
    .req_b(req_b),
    .mul_a(mul_a),
    .mul_b(mul_b),
    .mul_product(mul_product),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_id(rsp_id),
    .rsp_product(rsp_product)
`ifdef MUL_SHARE_ARB_STATS_EN
    ,
    .ops_done(ops_done)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    #1;
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_id", 32'(rsp_id), 0);
    chk("rst_rsp_product", 32'(rsp_product), 0);
    chk("rst_mul_a", 32'(mul_a), 0);
    chk("rst_mul_b", 32'(mul_b), 0);
`ifdef MUL_SHARE_ARB_STATS_EN
    chk("rst_ops_done", 32'(ops_done), 0);
`endif
    @(negedge clk); @(negedge clk); rst_n = 1'b1;

    // 1: single request on requester 1, a=3 b=2
    @(negedge clk);
    req_a = 8'b0000_1100; req_b = 8'b0000_1000; req_valid = 4'b0010;
    #1 chk("t1_ready", 32'(req_ready), 32'h2);
    step();
    req_valid = '0;
    chk("t1_mul_a", 32'(mul_a), 3);
    chk("t1_mul_b", 32'(mul_b), 2);
    chk("t1_mul_ready", 32'(req_ready), 0);
    chk("t1_mul_rsp_valid", 32'(rsp_valid), 0);
    step();
    chk("t1_rsp_valid", 32'(rsp_valid), 1);
    chk("t1_rsp_product", 32'(rsp_product), 32'h6);
    chk("t1_rsp_id", 32'(rsp_id), 1);
    rsp_ready = 1'b1;
    step();
    chk("t1_idle_rsp_valid", 32'(rsp_valid), 0);

    // 2: all requesters valid from reset, grants 0,1,2,3,0 three cycles apart
    rst_n = 1'b0; #1; rst_n = 1'b1;
    req_a = 8'hE4; req_b = 8'hFF; req_valid = 4'hF; rsp_ready = 1'b1;
    #1;
    for (int g = 0; g < 5; g++) begin
      chk($sformatf("t2_ready_%0d", g), 32'(req_ready), 32'(4'b0001 << (g % 4)));
      step();
      chk($sformatf("t2_mul_ready_%0d", g), 32'(req_ready), 0);
      step();
      chk($sformatf("t2_rsp_id_%0d", g), 32'(rsp_id), 32'(g % 4));
      chk($sformatf("t2_rsp_product_%0d", g), 32'(rsp_product), 32'((g % 4) * 3));
`ifdef MUL_SHARE_ARB_STATS_EN
      chk($sformatf("t2_ops_done_%0d", g), 32'(ops_done), 32'(g));
`endif
      if (g == 4) req_valid = '0;
      step();
    end
    chk("t2_idle_ready", 32'(req_ready), 0);

    // 3: grant 2, then 1 and 3 pending -> 3 first, then 1
    req_valid = 4'b0100;
    #1 chk("t3_ready2", 32'(req_ready), 32'h4);
    step();
    req_valid = '0;
    step();
    chk("t3_rsp_id2", 32'(rsp_id), 2);
    chk("t3_rsp_product2", 32'(rsp_product), 6);
    req_valid = 4'b1010;
    #1 chk("t3_resp_ready", 32'(req_ready), 0);
    step();
    chk("t3_ready3", 32'(req_ready), 32'h8);
    step();
    req_valid = 4'b0010;
    step();
    chk("t3_rsp_id3", 32'(rsp_id), 3);
    chk("t3_rsp_product3", 32'(rsp_product), 9);
    step();
    chk("t3_ready1", 32'(req_ready), 32'h2);
    step();
    req_valid = '0;
    step();
    chk("t3_rsp_id1", 32'(rsp_id), 1);
    chk("t3_rsp_product1", 32'(rsp_product), 3);
    step();

    // 4: backpressure for 5 cycles with requests pending
    rsp_ready = 1'b0; req_a = 8'hE6;
    req_valid = 4'b0001;
    #1 chk("t4_ready0", 32'(req_ready), 32'h1);
    step();
    req_valid = 4'b0101;
    step();
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("t4_rsp_valid_%0d", c), 32'(rsp_valid), 1);
      chk($sformatf("t4_rsp_id_%0d", c), 32'(rsp_id), 0);
      chk($sformatf("t4_rsp_product_%0d", c), 32'(rsp_product), 6);
      chk($sformatf("t4_ready_%0d", c), 32'(req_ready), 0);
      chk($sformatf("t4_mul_a_%0d", c), 32'(mul_a), 2);
      if (c < 4) step();
    end
    rsp_ready = 1'b1;
    step();
    chk("t4_idle_rsp_valid", 32'(rsp_valid), 0);
    chk("t4_idle_ready2", 32'(req_ready), 32'h4);
    req_valid = '0;
    #1 chk("t4_dropped_ready", 32'(req_ready), 0);

    // 5: all 16 operand pairs through requester 0
    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) begin
        step();
        req_a[1:0] = 2'(a); req_b[1:0] = 2'(b); req_valid = 4'b0001;
        #1 chk($sformatf("t5_ready_%0d_%0d", a, b), 32'(req_ready), 1);
        step();
        req_valid = '0;
        step();
        chk($sformatf("t5_product_%0d_%0d", a, b), 32'(rsp_product), 32'(a * b));
      end
    end
    step();

    // 6: reset during MUL, then requester 0 first
    req_a = 8'hE6; req_b = 8'hFF;
    req_valid = 4'b1000;
    #1 chk("t6_ready3", 32'(req_ready), 32'h8);
    step();
    req_valid = '0;
    chk("t6_mul_a", 32'(mul_a), 3);
    chk("t6_mul_b", 32'(mul_b), 3);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_async_mul_a", 32'(mul_a), 0);
    chk("t6_async_mul_b", 32'(mul_b), 0);
    chk("t6_async_rsp_valid", 32'(rsp_valid), 0);
    chk("t6_async_rsp_id", 32'(rsp_id), 0);
    chk("t6_async_rsp_product", 32'(rsp_product), 0);
`ifdef MUL_SHARE_ARB_STATS_EN
    chk("t6_async_ops_done", 32'(ops_done), 0);
`endif
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      chk($sformatf("t6_no_rsp_%0d", c), 32'(rsp_valid), 0);
    end
    req_valid = 4'hF;
    #1 chk("t6_ready0_first", 32'(req_ready), 32'h1);
    req_valid = '0;
    step();
    chk("t6_final_rsp_valid", 32'(rsp_valid), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
